// File: rtl/ibex_sram_arb_pkg.sv
// Shared types and helpers for the Ibex instr/data single-port SRAM arbiter.
// Port encoding doubles as the round-robin "last granted" state.
package ibex_sram_arb_pkg;

  typedef enum logic {
    ArbInstr = 1'b0,
    ArbData  = 1'b1
  } arb_port_e;

  typedef struct packed {
    logic      valid;
    arb_port_e port;
    logic      err;
  } resp_t;

  // 33/34-bit compare so a Depth*4 of 2^32 cannot overflow the limit.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth);
    logic [31:0] off;
    logic [33:0] lim;
    off = addr - base;
    lim = {2'b00, depth} << 2;
    return ({2'b00, off} < lim);
  endfunction

endpackage

// File: rtl/ibex_sram_arb_rr.sv
// Two-way picker: single requester always wins; on conflict either data wins (enable=0)
// or the port not granted last wins (enable=1). Combinational grant, no backpressure.
module ibex_sram_arb_rr
  import ibex_sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt_o,
  output arb_port_e  last_q
);

  always_comb begin
    gnt_o = req;
    if (req == 2'b11) begin
      if (!enable || (last_q == ArbInstr)) begin
        gnt_o = 2'b10;
      end else begin
        gnt_o = 2'b01;
      end
    end
  end

  // Reset to ArbData so the first contended round goes to instr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ArbData;
    end else if (|gnt_o) begin
      last_q <= gnt_o[1] ? ArbData : ArbInstr;
    end
  end

endmodule

// File: rtl/ibex_sram_arbiter.sv
// Shares a 1-cycle-latency single-port SRAM between Ibex instr/data ports; grant same cycle, rvalid +1 cycle, never stalls.
// Optional per-port stall counters under SRAM_ARB_STALL_CNT_EN.
module ibex_sram_arbiter
  import ibex_sram_arb_pkg::*;
#(
  parameter int unsigned Depth        = 8192,
  parameter logic [31:0] BaseAddr     = 32'h0010_0000,
  parameter bit          DataPriority = 1'b0,
  localparam int         AW           = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,

  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,

  output logic          ram_req_o,
  output logic          ram_we_o,
  output logic [3:0]    ram_be_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_wdata_o,
  input  logic          ram_rvalid_i,
  input  logic [31:0]   ram_rdata_i
`ifdef SRAM_ARB_STALL_CNT_EN
 ,output logic [31:0]   instr_stall_cnt_o,
  output logic [31:0]   data_stall_cnt_o
`endif
);

  logic [1:0]  req;
  logic [1:0]  gnt;
  arb_port_e   rr_last_q;
  logic        sel_data;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic [31:0] off;
  logic        addr_ok;
  resp_t       resp_q;
  logic        wr_q;
  logic        rd_ok;
  logic [31:0] rdata_mux;

  // Requests are masked while in reset so every output sits at 0.
  assign req = {data_req_i, instr_req_i} & {2{rst_ni}};

  ibex_sram_arb_rr u_rr (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .req    (req),
    .enable (DataPriority == 1'b0),
    .gnt_o  (gnt),
    .last_q (rr_last_q)
  );

  assign instr_gnt_o = gnt[0];
  assign data_gnt_o  = gnt[1];
  assign sel_data    = gnt[1];
  assign any_gnt     = |gnt;

  assign sel_addr = sel_data ? data_addr_i : instr_addr_i;
  assign off      = sel_addr - BaseAddr;
  assign addr_ok  = in_range(sel_addr, BaseAddr, Depth);

  assign ram_req_o   = any_gnt && addr_ok;
  assign ram_we_o    = ram_req_o && sel_data && data_we_i;
  assign ram_be_o    = ram_req_o ? (sel_data ? data_be_i : 4'hF) : 4'h0;
  assign ram_addr_o  = ram_req_o ? AW'(off >> 2) : '0;
  assign ram_wdata_o = (ram_req_o && sel_data) ? data_wdata_i : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      resp_q.valid <= any_gnt;
      resp_q.port  <= sel_data ? ArbData : ArbInstr;
      resp_q.err   <= !addr_ok;
      wr_q         <= sel_data && data_we_i;
    end
  end

  // Write responses and errors carry zero data; ram_rvalid_i is only checked, never used.
  assign rd_ok     = resp_q.valid && !resp_q.err && !wr_q;
  assign rdata_mux = rd_ok ? ram_rdata_i : 32'h0;

  assign instr_rvalid_o = resp_q.valid && (resp_q.port == ArbInstr);
  assign instr_err_o    = instr_rvalid_o && resp_q.err;
  assign instr_rdata_o  = instr_rvalid_o ? rdata_mux : 32'h0;

  assign data_rvalid_o  = resp_q.valid && (resp_q.port == ArbData);
  assign data_err_o     = data_rvalid_o && resp_q.err;
  assign data_rdata_o   = data_rvalid_o ? rdata_mux : 32'h0;

`ifdef SRAM_ARB_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_stall_cnt_o <= 32'h0;
      data_stall_cnt_o  <= 32'h0;
    end else begin
      if (instr_req_i && !gnt[0] && (instr_stall_cnt_o != 32'hFFFF_FFFF)) begin
        instr_stall_cnt_o <= instr_stall_cnt_o + 32'd1;
      end
      if (data_req_i && !gnt[1] && (data_stall_cnt_o != 32'hFFFF_FFFF)) begin
        data_stall_cnt_o <= data_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

  sram_rvalid_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ram_rvalid_i == (resp_q.valid && !resp_q.err));

  rr_alternates: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((req == 2'b11) && (DataPriority == 1'b0)) |-> (gnt[1] == (rr_last_q == ArbInstr)));

endmodule

// File: tb/tb_ibex_sram_arbiter.sv
// Bench for ibex_sram_arbiter: round-robin instance under a per-cycle scoreboard, plus a
// data-priority instance exercised with directed vectors.
module tb_ibex_sram_arbiter;

  localparam int unsigned DEPTH = 8192;
  localparam logic [31:0] BASE  = 32'h0010_0000;

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Round-robin DUT signals
  logic        instr_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [31:0] instr_addr = BASE, data_addr = BASE, data_wdata = 32'h0;
  logic [3:0]  data_be = 4'h0;
  logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
  logic [31:0] instr_rdata, data_rdata;
  logic        ram_req, ram_we, ram_rvalid;
  logic [3:0]  ram_be;
  logic [12:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  // Data-priority DUT signals
  logic        p_instr_req = 1'b0, p_data_req = 1'b0;
  logic [31:0] p_addr = BASE;
  logic        p_instr_gnt, p_instr_rvalid, p_instr_err, p_data_gnt, p_data_rvalid, p_data_err;
  logic [31:0] p_instr_rdata, p_data_rdata;
  logic        p_ram_req, p_ram_we, p_ram_rvalid;
  logic [3:0]  p_ram_be;
  logic [12:0] p_ram_addr;
  logic [31:0] p_ram_wdata;
  logic [31:0] p_ram_rdata;
  assign p_ram_rdata = 32'h0;

`ifdef SRAM_ARB_STALL_CNT_EN
  logic [31:0] instr_stall, data_stall, p_instr_stall, p_data_stall;
`endif

  ibex_sram_arbiter #(.Depth(DEPTH), .BaseAddr(BASE), .DataPriority(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata)
`ifdef SRAM_ARB_STALL_CNT_EN
   ,.instr_stall_cnt_o(instr_stall), .data_stall_cnt_o(data_stall)
`endif
  );

  ibex_sram_arbiter #(.Depth(DEPTH), .BaseAddr(BASE), .DataPriority(1'b1)) dut_p (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(p_instr_req), .instr_addr_i(p_addr), .instr_gnt_o(p_instr_gnt),
    .instr_rvalid_o(p_instr_rvalid), .instr_rdata_o(p_instr_rdata), .instr_err_o(p_instr_err),
    .data_req_i(p_data_req), .data_we_i(1'b0), .data_be_i(4'hF), .data_addr_i(p_addr),
    .data_wdata_i(32'h0), .data_gnt_o(p_data_gnt), .data_rvalid_o(p_data_rvalid),
    .data_rdata_o(p_data_rdata), .data_err_o(p_data_err),
    .ram_req_o(p_ram_req), .ram_we_o(p_ram_we), .ram_be_o(p_ram_be), .ram_addr_o(p_ram_addr),
    .ram_wdata_o(p_ram_wdata), .ram_rvalid_i(p_ram_rvalid), .ram_rdata_i(p_ram_rdata)
`ifdef SRAM_ARB_STALL_CNT_EN
   ,.instr_stall_cnt_o(p_instr_stall), .data_stall_cnt_o(p_data_stall)
`endif
  );

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h0001_0003) ^ 32'hA5A5_5A5A;
  endfunction

  // Behavioural single-port SRAM: answers every request one cycle later.
  logic [31:0] sram [DEPTH];
  logic [31:0] sram_w;
  bit          sram_init;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rvalid <= 1'b0;
      if (!sram_init) begin
        for (int i = 0; i < DEPTH; i++) sram[i] <= pat(i);
        sram_init <= 1'b1;
      end
    end else begin
      ram_rvalid <= ram_req;
      if (ram_req) begin
        sram_w = sram[ram_addr];
        if (ram_we) begin
          for (int b = 0; b < 4; b++) if (ram_be[b]) sram_w[8*b +: 8] = ram_wdata[8*b +: 8];
          sram[ram_addr] <= sram_w;
        end
        ram_rdata <= sram_w;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_ram_rvalid <= 1'b0;
    else        p_ram_rvalid <= p_ram_req;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected grant from the arbitration rules, one pending response record, word memory.
  logic [31:0] mdl [DEPTH];
  bit          m_last_data;
  bit          pend_vld, pend_data, pend_err;
  logic [31:0] pend_rdata;
  int unsigned sc_i, sc_d;

  initial begin : compare
    bit          g_any, g_d, inr;
    logic [31:0] a, off, w;
    for (int i = 0; i < DEPTH; i++) mdl[i] = pat(i);
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_ctrl", {instr_gnt, data_gnt, instr_rvalid, data_rvalid, instr_err, data_err,
                         ram_req, ram_we, ram_be}, 64'h0);
        chk("rst_rdata", {instr_rdata, data_rdata}, 64'h0);
        m_last_data = 1'b1;
        pend_vld    = 1'b0;
        sc_i        = 0;
        sc_d        = 0;
      end else begin
        g_any = instr_req || data_req;
        g_d   = (instr_req && data_req) ? !m_last_data : data_req;
        chk("instr_gnt", instr_gnt, g_any && !g_d);
        chk("data_gnt", data_gnt, g_any && g_d);
        a   = g_d ? data_addr : instr_addr;
        off = a - BASE;
        inr = off < DEPTH * 4;
        chk("ram_req", ram_req, g_any && inr);
        if (g_any && inr) begin
          chk("ram_addr", ram_addr, off >> 2);
          chk("ram_we", ram_we, g_d && data_we);
          chk("ram_be", ram_be, g_d ? data_be : 4'hF);
          if (g_d && data_we) chk("ram_wdata", ram_wdata, data_wdata);
        end
        chk("instr_rvalid", instr_rvalid, pend_vld && !pend_data);
        chk("data_rvalid", data_rvalid, pend_vld && pend_data);
        chk("instr_err", instr_err, pend_vld && !pend_data && pend_err);
        chk("data_err", data_err, pend_vld && pend_data && pend_err);
        chk("instr_rdata", instr_rdata, (pend_vld && !pend_data) ? pend_rdata : 32'h0);
        chk("data_rdata", data_rdata, (pend_vld && pend_data) ? pend_rdata : 32'h0);
`ifdef SRAM_ARB_STALL_CNT_EN
        chk("instr_stall", instr_stall, sc_i);
        chk("data_stall", data_stall, sc_d);
        if (instr_req && !(g_any && !g_d)) sc_i++;
        if (data_req && !(g_any && g_d)) sc_d++;
`endif
        pend_vld = g_any;
        if (g_any) begin
          pend_data   = g_d;
          pend_err    = !inr;
          m_last_data = g_d;
          if (!inr) begin
            pend_rdata = 32'h0;
          end else if (g_d && data_we) begin
            pend_rdata = 32'h0;
            w = mdl[off >> 2];
            for (int b = 0; b < 4; b++) if (data_be[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
            mdl[off >> 2] = w;
          end else begin
            pend_rdata = mdl[off >> 2];
          end
        end
      end
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd);
    @(negedge clk);
    instr_req = ir; instr_addr = ia;
    data_req = dr; data_we = dwe; data_be = dbe; data_addr = da; data_wdata = dwd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, BASE, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_req = 1'b0; data_req = 1'b0;
    p_instr_req = 1'b0; p_data_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return BASE - 32'(4 * $urandom_range(1, 4));
    if (r == 1) return BASE + DEPTH * 4 + 32'(4 * $urandom_range(0, 3));
    return BASE + 32'(4 * $urandom_range(0, 63));
  endfunction

  initial begin : stim
    #1;
    chk("reset_gnt_rvalid", {instr_gnt, data_gnt, instr_rvalid, data_rvalid, ram_req}, 64'h0);
    do_reset();

    // 1: contended reads alternate instr, data, ...
    drive(1'b1, BASE, 1'b1, 1'b0, 4'hF, BASE, 32'h0);
    chk("t1_c0_gnt", {instr_gnt, data_gnt}, 64'h2);
    drive(1'b1, BASE, 1'b1, 1'b0, 4'hF, BASE, 32'h0);
    chk("t1_c1_gnt", {instr_gnt, data_gnt}, 64'h1);
    chk("t1_c1_rv", {instr_rvalid, data_rvalid}, 64'h2);
    drive(1'b1, BASE, 1'b1, 1'b0, 4'hF, BASE, 32'h0);
    chk("t1_c2_gnt", {instr_gnt, data_gnt}, 64'h2);
    chk("t1_c2_rv", {instr_rvalid, data_rvalid}, 64'h1);
    drive(1'b1, BASE, 1'b1, 1'b0, 4'hF, BASE, 32'h0);
    chk("t1_c3_gnt", {instr_gnt, data_gnt}, 64'h1);
    idle();
    chk("t1_tail_rv", {instr_rvalid, data_rvalid}, 64'h1);
    chk("t1_tail_rdata", data_rdata, 32'hA5A5_5A5A);

    // 2: write then instr read back through the same word
    drive(1'b0, BASE, 1'b1, 1'b1, 4'hF, BASE + 8, 32'hDEAD_BEEF);
    chk("t2_wr_addr", ram_addr, 64'd2);
    chk("t2_wr_we", {data_gnt, ram_req, ram_we}, 64'h7);
    drive(1'b1, BASE + 8, 1'b0, 1'b0, 4'h0, BASE, 32'h0);
    chk("t2_rd_addr", ram_addr, 64'd2);
    chk("t2_wr_resp", {data_rvalid, data_err, data_rdata}, {2'b10, 32'h0});
    idle();
    chk("t2_rd_data", instr_rdata, 32'hDEAD_BEEF);
    chk("t2_rd_rv", {instr_rvalid, instr_err}, 64'h2);

    // 3: out-of-range below and above the window
    drive(1'b0, BASE, 1'b1, 1'b0, 4'hF, BASE - 4, 32'h0);
    chk("t3_lo_ramreq", {data_gnt, ram_req}, 64'h2);
    drive(1'b0, BASE, 1'b1, 1'b0, 4'hF, BASE + DEPTH * 4, 32'h0);
    chk("t3_hi_ramreq", {data_gnt, ram_req}, 64'h2);
    chk("t3_lo_resp", {data_rvalid, data_err, data_rdata}, {2'b11, 32'h0});
    idle();
    chk("t3_hi_resp", {data_rvalid, data_err, data_rdata}, {2'b11, 32'h0});

    // 4: data-priority instance, both requests held
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      p_instr_req = 1'b1; p_data_req = 1'b1; p_addr = BASE + 4;
      #1;
      chk("t4_gnt", {p_instr_gnt, p_data_gnt}, 64'h1);
      if (i > 0) chk("t4_rvalid", {p_instr_rvalid, p_data_rvalid}, 64'h1);
    end
    @(negedge clk);
    p_instr_req = 1'b0; p_data_req = 1'b0;
    #1;
    chk("t4_last_rvalid", {p_instr_rvalid, p_data_rvalid, p_data_err}, 64'h2);
`ifdef SRAM_ARB_STALL_CNT_EN
    chk("t4_instr_stall", p_instr_stall, 64'd5);
    chk("t4_data_stall", p_data_stall, 64'd0);
`endif

    // 5: reset while a data read is in flight
    do_reset();
    drive(1'b0, BASE, 1'b1, 1'b0, 4'hF, BASE + 12, 32'h0);
    chk("t5_gnt", data_gnt, 64'h1);
    @(negedge clk);
    rst_n = 1'b0; data_req = 1'b0;
    #1;
    chk("t5_rst_outs", {data_rvalid, data_err, data_rdata, ram_req}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("t5_no_rvalid", {instr_rvalid, data_rvalid}, 64'h0);
    drive(1'b1, BASE, 1'b1, 1'b0, 4'hF, BASE + 4, 32'h0);
    chk("t5_first_rr", {instr_gnt, data_gnt}, 64'h2);

    // 6: random traffic under the scoreboard
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom());
    end
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
